// File: rtl/crack_result_collector.sv
// Result collector for the RC4 key-search cores: latches the first winning key,
// flags exhaustion, broadcasts an abort and times the session.
module crack_result_collector #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24,
  parameter int IDX_W     = 2,
  parameter int CNT_W     = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       found,
  input  logic [NUM_CORES-1:0]       not_found,
  input  logic [NUM_CORES*KEY_W-1:0] key_flat,
  output logic [KEY_W-1:0]           result_key,
  output logic [IDX_W-1:0]           result_core,
  output logic                       result_valid,
  output logic                       exhausted,
  output logic                       busy,
  output logic                       core_abort,
  output logic [NUM_CORES-1:0]       done_mask,
  output logic [CNT_W-1:0]           elapsed
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCHING,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [IDX_W-1:0]     core_q, core_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     elapsed_q, elapsed_d;

  logic                 win_any;
  logic [IDX_W-1:0]     win_idx;
  logic [KEY_W-1:0]     win_key;

  // Descending scan so the lowest-indexed finder is the last one written.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (found[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
        win_key = key_flat[i*KEY_W +: KEY_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    core_d    = core_q;
    mask_d    = mask_q;
    elapsed_d = elapsed_q;
    case (state_q)
      SEARCHING: begin
        if (elapsed_q != {CNT_W{1'b1}}) begin
          elapsed_d = elapsed_q + CNT_W'(1);
        end
        mask_d = mask_q | found | not_found;
        if (win_any) begin
          state_d = FOUND;
          key_d   = win_key;
          core_d  = win_idx;
        end else if (&(mask_q | not_found)) begin
          state_d = EXHAUSTED;
        end
      end
      default: begin
        if (start) begin
          state_d   = SEARCHING;
          key_d     = '0;
          core_d    = '0;
          mask_d    = '0;
          elapsed_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      key_q     <= '0;
      core_q    <= '0;
      mask_q    <= '0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      core_q    <= core_d;
      mask_q    <= mask_d;
      elapsed_q <= elapsed_d;
    end
  end

  // key_q/core_q are cleared on every entry to SEARCHING, so they are zero outside FOUND.
  assign result_key   = key_q;
  assign result_core  = core_q;
  assign result_valid = (state_q == FOUND);
  assign exhausted    = (state_q == EXHAUSTED);
  assign busy         = (state_q == SEARCHING);
  assign core_abort   = result_valid | exhausted;
  assign done_mask    = mask_q;
  assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_crack_result_collector.sv
// Directed bench for crack_result_collector: a per-cycle vector table plus
// hand sequences for latency, exhaustion timing, async reset and saturation.
module tb_crack_result_collector;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [3:0]  found;
  logic [3:0]  not_found;
  logic [95:0] key_flat;

  logic [23:0] result_key;
  logic [1:0]  result_core;
  logic        result_valid, exhausted, busy, core_abort;
  logic [3:0]  done_mask;
  logic [31:0] elapsed;

  logic [23:0] s_result_key;
  logic [1:0]  s_result_core;
  logic        s_result_valid, s_exhausted, s_busy, s_core_abort;
  logic [3:0]  s_done_mask;
  logic [3:0]  s_elapsed;

  int n_compared = 0;
  int n_failed   = 0;

  crack_result_collector #(.NUM_CORES(4), .KEY_W(24), .IDX_W(2), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .found(found),
    .not_found(not_found), .key_flat(key_flat), .result_key(result_key),
    .result_core(result_core), .result_valid(result_valid), .exhausted(exhausted),
    .busy(busy), .core_abort(core_abort), .done_mask(done_mask), .elapsed(elapsed)
  );

  crack_result_collector #(.NUM_CORES(4), .KEY_W(24), .IDX_W(2), .CNT_W(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .found(found),
    .not_found(not_found), .key_flat(key_flat), .result_key(s_result_key),
    .result_core(s_result_core), .result_valid(s_result_valid), .exhausted(s_exhausted),
    .busy(s_busy), .core_abort(s_core_abort), .done_mask(s_done_mask), .elapsed(s_elapsed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        start;
    logic [3:0]  found;
    logic [3:0]  not_found;
    logic [95:0] key_flat;
    logic        e_valid;
    logic        e_exh;
    logic        e_busy;
    logic [23:0] e_key;
    logic [1:0]  e_core;
    logic [3:0]  e_mask;
    logic [31:0] e_elapsed;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic e_exh,
                           input logic e_busy, input logic [23:0] e_key,
                           input logic [1:0] e_core, input logic [3:0] e_mask,
                           input logic [31:0] e_elapsed);
    check({tag, ".result_valid"}, 32'(result_valid), 32'(e_valid));
    check({tag, ".exhausted"},    32'(exhausted),    32'(e_exh));
    check({tag, ".busy"},         32'(busy),         32'(e_busy));
    check({tag, ".core_abort"},   32'(core_abort),   32'(e_valid | e_exh));
    check({tag, ".result_key"},   32'(result_key),   32'(e_key));
    check({tag, ".result_core"},  32'(result_core),  32'(e_core));
    check({tag, ".done_mask"},    32'(done_mask),    32'(e_mask));
    check({tag, ".elapsed"},      elapsed,           e_elapsed);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; found = '0; not_found = '0;
    reset_n = 1'b0;
    #7;
    reset_n = 1'b1;
    #1;
  endtask

  localparam logic [95:0] KF  = {24'hD33333, 24'hC22222, 24'hB11111, 24'hA00000};
  localparam logic [95:0] KF2 = {24'h0F0F0F, 24'h123456, 24'h654321, 24'hFFFFFF};

  initial begin
    reset_n = 1'b0; start = 1'b0; found = '0; not_found = '0; key_flat = KF;

    // Vector table: drive one row per cycle, compare after the edge.
    vecs[0]  = '{1'b0, 4'b0100, 4'b0000, KF,  1'b0, 1'b0, 1'b0, 24'h0,      2'd0, 4'b0000, 32'd0};
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0000, 32'd0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0000, 32'd1};
    vecs[3]  = '{1'b0, 4'b1010, 4'b0000, KF,  1'b1, 1'b0, 1'b0, 24'hB11111, 2'd1, 4'b1010, 32'd2};
    vecs[4]  = '{1'b0, 4'b0001, 4'b1111, KF2, 1'b1, 1'b0, 1'b0, 24'hB11111, 2'd1, 4'b1010, 32'd2};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0000, 32'd0};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0111, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0111, 32'd1};
    vecs[7]  = '{1'b0, 4'b1000, 4'b1111, KF,  1'b1, 1'b0, 1'b0, 24'hD33333, 2'd3, 4'b1111, 32'd2};
    vecs[8]  = '{1'b1, 4'b0000, 4'b0000, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0000, 32'd0};
    vecs[9]  = '{1'b1, 4'b0000, 4'b0000, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0000, 32'd1};
    vecs[10] = '{1'b1, 4'b0001, 4'b0000, KF,  1'b1, 1'b0, 1'b0, 24'hA00000, 2'd0, 4'b0001, 32'd2};
    vecs[11] = '{1'b1, 4'b0000, 4'b0000, KF,  1'b0, 1'b0, 1'b1, 24'h0,      2'd0, 4'b0000, 32'd0};

    #3;
    check_all("reset", 1'b0, 1'b0, 1'b0, 24'h0, 2'd0, 4'b0000, 32'd0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; found = vecs[i].found;
      not_found = vecs[i].not_found; key_flat = vecs[i].key_flat;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_exh, vecs[i].e_busy,
                vecs[i].e_key, vecs[i].e_core, vecs[i].e_mask, vecs[i].e_elapsed);
    end

    // Found on core 2 at the tenth searching cycle, then stays latched.
    do_reset();
    key_flat = KF;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    check_all("t1_pre", 1'b0, 1'b0, 1'b1, 24'h0, 2'd0, 4'b0000, 32'd9);
    key_flat[48 +: 24] = 24'h000249;
    found = 4'b0100;
    tick();
    check_all("t1_found", 1'b1, 1'b0, 1'b0, 24'h000249, 2'd2, 4'b0100, 32'd10);
    found = 4'b0001; key_flat = KF2;
    tick(); tick();
    check_all("t1_hold", 1'b1, 1'b0, 1'b0, 24'h000249, 2'd2, 4'b0100, 32'd10);

    // Staggered not_found: cores 0..3 at cycles 5, 9, 9, 20.
    do_reset();
    found = '0; not_found = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5)  not_found[0] = 1'b1;
      if (c == 9)  not_found[2:1] = 2'b11;
      if (c == 20) not_found[3] = 1'b1;
      tick();
      if (c == 9)  check_all("t3_c9",  1'b0, 1'b0, 1'b1, 24'h0, 2'd0, 4'b0111, 32'd9);
      if (c == 19) check_all("t3_c19", 1'b0, 1'b0, 1'b1, 24'h0, 2'd0, 4'b0111, 32'd19);
    end
    check_all("t3_exh", 1'b0, 1'b1, 1'b0, 24'h0, 2'd0, 4'b1111, 32'd20);
    not_found = '0; found = 4'b0010;
    tick();
    check_all("t3_hold", 1'b0, 1'b1, 1'b0, 24'h0, 2'd0, 4'b1111, 32'd20);
    found = '0;

    // Asynchronous reset in the middle of a session.
    start = 1'b1; tick(); start = 1'b0;
    not_found = 4'b0011;
    tick(); tick();
    check_all("t6_pre", 1'b0, 1'b0, 1'b1, 24'h0, 2'd0, 4'b0011, 32'd2);
    #3;
    reset_n = 1'b0;
    #1;
    check_all("t6_async", 1'b0, 1'b0, 1'b0, 24'h0, 2'd0, 4'b0000, 32'd0);
    check("t6_sat_elapsed_reset", 32'(s_elapsed), 32'd0);
    #8;
    reset_n = 1'b1;
    not_found = '0;
    #1;

    // Narrow counter saturates at 15 and does not wrap.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 14; c++) tick();
    check("sat_14", 32'(s_elapsed), 32'd14);
    for (int c = 15; c <= 20; c++) tick();
    check("sat_hold", 32'(s_elapsed), 32'd15);
    check("sat_busy", 32'(s_busy), 32'd1);
    check("sat_wide", elapsed, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
